// File: rtl/exec_stage_md.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and RV32M multiply/divide, registered into EX/MEM.
// Latency: 1 cycle for ALU, MUL and special-case DIV; XLEN+2 cycles for a normal DIV/REM (issue, XLEN iterations, done).
// Backpressure: stall_o holds upstream for XLEN+1 cycles of a divide; EX/MEM takes bubbles meanwhile. MDU built only with EXEC_MD_EXT_EN.
module exec_stage_md #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [6:0]      op,
    input  logic [3:0]      alu_ctrl,
    input  logic            alu_src,
    input  logic            md_en,
    input  logic [2:0]      md_op,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [XLEN-1:0] rdata1,
    input  logic [XLEN-1:0] rdata2,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] wb_data,
    input  logic [4:0]      rd,
    input  logic            branch,
    input  logic [2:0]      branch_type,
    input  logic            reg_write,
    input  logic            mem_write,
    input  logic [1:0]      result_sel,
    input  logic [1:0]      mem_type,
    input  logic            mem_unsigned,
    output logic [XLEN-1:0] pc_branch,
    output logic            pc_src,
    output logic            stall_o,
    output logic [6:0]      op_o,
    output logic            reg_write_o,
    output logic            mem_write_o,
    output logic [1:0]      result_sel_o,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [XLEN-1:0] alu_result_o,
    output logic [1:0]      mem_type_o,
    output logic            mem_unsigned_o
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // ALU encodings
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_PASB = 4'd10;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b_raw;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] ex_result;
    logic            zero;
    logic            br_cond;
    logic            bubble;

    always_comb begin
        case (fwd_a)
            2'b01:   op_a = wb_data;
            2'b10:   op_a = alu_result_o;
            default: op_a = rdata1;
        endcase
        case (fwd_b)
            2'b01:   op_b_raw = wb_data;
            2'b10:   op_b_raw = alu_result_o;
            default: op_b_raw = rdata2;
        endcase
    end

    assign op_b = alu_src ? imm : op_b_raw;

    always_comb begin
        case (alu_ctrl)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
            ALU_SLTU: alu_res = XLEN'(op_a < op_b);
            ALU_SLL:  alu_res = op_a << op_b[SHW-1:0];
            ALU_SRL:  alu_res = op_a >> op_b[SHW-1:0];
            ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> op_b[SHW-1:0]);
            ALU_PASB: alu_res = op_b;
            default:  alu_res = op_a + op_b;
        endcase
        if (op == OP_JALR) begin
            alu_res[0] = 1'b0;
        end
    end

    assign zero      = (alu_res == '0);
    assign pc_branch = pc + imm;

    always_comb begin
        case (branch_type)
            BR_BEQ:           br_cond = zero;
            BR_BNE:           br_cond = !zero;
            BR_BLT, BR_BLTU:  br_cond = alu_res[0];
            BR_BGE, BR_BGEU:  br_cond = !alu_res[0];
            default:          br_cond = 1'b0;
        endcase
    end

    assign pc_src = !flush && branch && (br_cond || op == OP_JAL || op == OP_JALR);

`ifdef EXEC_MD_EXT_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

    localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state, state_nxt;
    logic [SHW-1:0]  cnt;
    logic [XLEN-1:0] dvd_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] rem_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic            sel_rem_q;
    logic            stall;

    // Multiplier: both operands sign/zero-extended to 2*XLEN so one unsigned product covers all signedness mixes.
    logic            mul_sa, mul_sb;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_prod;
    logic [XLEN-1:0] mul_res;

    assign mul_sa   = (md_op == 3'd1) || (md_op == 3'd2);
    assign mul_sb   = (md_op == 3'd1);
    assign mul_a    = {{XLEN{mul_sa & op_a[XLEN-1]}}, op_a};
    assign mul_b    = {{XLEN{mul_sb & op_b_raw[XLEN-1]}}, op_b_raw};
    assign mul_prod = mul_a * mul_b;
    assign mul_res  = (md_op == 3'd0) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    logic            is_div, div_signed, a_neg, b_neg;
    logic            div_by_zero, div_ovf, div_special, issue;
    logic [XLEN-1:0] a_abs, b_abs, spec_res;

    assign is_div      = md_en && md_op[2];
    assign div_signed  = !md_op[0];
    assign a_neg       = div_signed && op_a[XLEN-1];
    assign b_neg       = div_signed && op_b_raw[XLEN-1];
    assign a_abs       = a_neg ? (~op_a + 1'b1) : op_a;
    assign b_abs       = b_neg ? (~op_b_raw + 1'b1) : op_b_raw;
    assign div_by_zero = (op_b_raw == '0);
    assign div_ovf     = div_signed && (op_a == INT_MIN) && (op_b_raw == '1);
    assign div_special = div_by_zero || div_ovf;
    assign issue       = (state == S_IDLE) && is_div && !flush && !div_special;

    always_comb begin
        spec_res = '0;
        if (div_by_zero) begin
            spec_res = md_op[1] ? op_a : '1;
        end else if (div_ovf) begin
            spec_res = md_op[1] ? '0 : op_a;
        end
    end

    // Restoring step: shift next dividend bit into the partial remainder and try to subtract.
    logic [XLEN:0]   rem_sh, rem_diff;
    logic [XLEN-1:0] q_fix, r_fix, div_res;

    assign rem_sh   = {rem_q, dvd_q[XLEN-1]};
    assign rem_diff = rem_sh - {1'b0, dvs_q};
    assign q_fix    = q_neg_q ? (~dvd_q + 1'b1) : dvd_q;
    assign r_fix    = r_neg_q ? (~rem_q + 1'b1) : rem_q;
    assign div_res  = sel_rem_q ? r_fix : q_fix;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            S_IDLE: begin
                if (issue) begin
                    stall     = 1'b1;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = !flush;
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Gate with rst so a reset mid-divide releases the hazard unit immediately.
    assign stall_o = rst && stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            sel_rem_q <= 1'b0;
        end else if (issue) begin
            cnt       <= '0;
            dvd_q     <= a_abs;
            dvs_q     <= b_abs;
            rem_q     <= '0;
            q_neg_q   <= a_neg ^ b_neg;
            r_neg_q   <= a_neg;
            sel_rem_q <= md_op[1];
        end else if (state == S_BUSY && !flush) begin
            cnt <= cnt + 1'b1;
            if (!rem_diff[XLEN]) begin
                rem_q <= rem_diff[XLEN-1:0];
                dvd_q <= {dvd_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= rem_sh[XLEN-1:0];
                dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        if (state == S_DONE) begin
            ex_result = div_res;
        end else if (md_en && !md_op[2]) begin
            ex_result = mul_res;
        end else if (md_en && div_special) begin
            ex_result = spec_res;
        end else begin
            ex_result = alu_res;
        end
    end
`else
    logic unused_md;
    assign unused_md = ^{md_en, md_op};
    assign stall_o   = 1'b0;
    assign ex_result = alu_res;
`endif

    assign bubble = stall_o || flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_o           <= '0;
            reg_write_o    <= 1'b0;
            mem_write_o    <= 1'b0;
            result_sel_o   <= '0;
            rd_o           <= '0;
            pc_plus4_o     <= '0;
            wdata_o        <= '0;
            alu_result_o   <= '0;
            mem_type_o     <= '0;
            mem_unsigned_o <= 1'b0;
        end else begin
            op_o           <= op;
            reg_write_o    <= reg_write && !bubble;
            mem_write_o    <= mem_write && !bubble;
            result_sel_o   <= result_sel;
            rd_o           <= rd;
            pc_plus4_o     <= pc_plus4;
            wdata_o        <= op_b_raw;
            alu_result_o   <= ex_result;
            mem_type_o     <= mem_type;
            mem_unsigned_o <= mem_unsigned;
        end
    end

endmodule

// File: tb/tb_exec_stage_md.sv
// Directed bench for exec_stage_md: vector table for single-cycle ops, hand sequences for divide, flush and reset.
module tb_exec_stage_md;

`ifdef EXEC_MD_EXT_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_XOR = 4'd4, A_SLT = 4'd5,
                           A_SLTU = 4'd6, A_SRL = 4'd8, A_SRA = 4'd9;
    localparam logic [6:0] OP_R = 7'b0110011, OP_B = 7'b1100011,
                           OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [6:0]  op;
    logic [3:0]  alu_ctrl;
    logic        alu_src, md_en;
    logic [2:0]  md_op;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] rdata1, rdata2, imm, pc, pc_plus4, wb_data;
    logic [4:0]  rd;
    logic        branch;
    logic [2:0]  branch_type;
    logic        reg_write, mem_write;
    logic [1:0]  result_sel, mem_type;
    logic        mem_unsigned;
    logic [31:0] pc_branch;
    logic        pc_src, stall_o;
    logic [6:0]  op_o;
    logic        reg_write_o, mem_write_o;
    logic [1:0]  result_sel_o;
    logic [4:0]  rd_o;
    logic [31:0] pc_plus4_o, wdata_o, alu_result_o;
    logic [1:0]  mem_type_o;
    logic        mem_unsigned_o;

    exec_stage_md #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .op(op), .alu_ctrl(alu_ctrl), .alu_src(alu_src),
        .md_en(md_en), .md_op(md_op), .fwd_a(fwd_a), .fwd_b(fwd_b), .rdata1(rdata1),
        .rdata2(rdata2), .imm(imm), .pc(pc), .pc_plus4(pc_plus4), .wb_data(wb_data), .rd(rd),
        .branch(branch), .branch_type(branch_type), .reg_write(reg_write), .mem_write(mem_write),
        .result_sel(result_sel), .mem_type(mem_type), .mem_unsigned(mem_unsigned),
        .pc_branch(pc_branch), .pc_src(pc_src), .stall_o(stall_o), .op_o(op_o),
        .reg_write_o(reg_write_o), .mem_write_o(mem_write_o), .result_sel_o(result_sel_o),
        .rd_o(rd_o), .pc_plus4_o(pc_plus4_o), .wdata_o(wdata_o), .alu_result_o(alu_result_o),
        .mem_type_o(mem_type_o), .mem_unsigned_o(mem_unsigned_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end else begin
            passed++;
        end
    endtask

    typedef struct {
        logic [3:0]  ctrl;
        logic        src;
        logic [1:0]  fa;
        logic [6:0]  opc;
        logic        br;
        logic [2:0]  bt;
        logic        mden;
        logic [2:0]  mdop;
        logic [31:0] a, b, im;
        logic [31:0] exp_md, exp_alu;
        logic        exp_pcs;
    } vec_t;

    vec_t vecs[24];

    task automatic set_instr(input logic [3:0] c, input logic s, input logic [1:0] fa, input logic [6:0] o,
                             input logic br, input logic [2:0] bt, input logic me, input logic [2:0] mo,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
        alu_ctrl = c; alu_src = s; fwd_a = fa; fwd_b = 2'b00; op = o; branch = br; branch_type = bt;
        md_en = me; md_op = mo; rdata1 = a; rdata2 = b; imm = im;
        reg_write = 1'b1; mem_write = 1'b0; flush = 1'b0;
    endtask

    // Runs a divide from issue until the cycle stall_o drops; returns stall and bubble counts.
    task automatic run_div(input logic [2:0] mo, input logic [31:0] a, input logic [31:0] b,
                           output int stalls, output int bubbles, output logic done);
        logic s;
        stalls = 0; bubbles = 0; done = 1'b0;
        set_instr(A_ADD, 1'b0, 2'b00, OP_R, 1'b0, 3'b000, 1'b1, mo, a, b, 32'h0);
        for (int c = 0; c < 100 && !done; c++) begin
            #3;
            s = stall_o;
            if (s) stalls++;
            @(posedge clk); #1;
            if (s && !reg_write_o) bubbles++;
            if (!s) done = 1'b1;
            if (c == 0) begin
                fwd_a = 2'b01;
                wb_data = 32'h0000_1234;
            end
        end
        fwd_a = 2'b00;
        wb_data = 32'h55;
    endtask

    initial begin
        int st, bb;
        logic dn;

        vecs[0]  = '{A_ADD,  1'b0, 2'b00, OP_R,    1'b0, 3'b000, 1'b0, 3'd0, 32'd100,      32'd0,        32'd0,  32'd100,      32'd100,      1'b0};
        vecs[1]  = '{A_ADD,  1'b1, 2'b10, OP_R,    1'b0, 3'b000, 1'b0, 3'd0, 32'd5,        32'h99,       32'd7,  32'd107,      32'd107,      1'b0};
        vecs[2]  = '{A_ADD,  1'b0, 2'b01, OP_R,    1'b0, 3'b000, 1'b0, 3'd0, 32'd9,        32'd1,        32'd0,  32'h56,       32'h56,       1'b0};
        vecs[3]  = '{A_SUB,  1'b0, 2'b00, OP_B,    1'b1, 3'b001, 1'b0, 3'd0, 32'd3,        32'd3,        32'h40, 32'd0,        32'd0,        1'b0};
        vecs[4]  = '{A_SUB,  1'b0, 2'b00, OP_B,    1'b1, 3'b001, 1'b0, 3'd0, 32'd3,        32'd4,        32'h40, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{A_SUB,  1'b0, 2'b00, OP_B,    1'b1, 3'b000, 1'b0, 3'd0, 32'd3,        32'd3,        32'h20, 32'd0,        32'd0,        1'b1};
        vecs[6]  = '{A_SUB,  1'b0, 2'b00, OP_B,    1'b1, 3'b000, 1'b0, 3'd0, 32'd3,        32'd4,        32'h20, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[7]  = '{A_SLT,  1'b0, 2'b00, OP_B,    1'b1, 3'b100, 1'b0, 3'd0, 32'hFFFFFFFF, 32'd1,        32'h10, 32'd1,        32'd1,        1'b1};
        vecs[8]  = '{A_SLTU, 1'b0, 2'b00, OP_B,    1'b1, 3'b111, 1'b0, 3'd0, 32'hFFFFFFFF, 32'd1,        32'h10, 32'd0,        32'd0,        1'b1};
        vecs[9]  = '{A_SLTU, 1'b0, 2'b00, OP_B,    1'b1, 3'b110, 1'b0, 3'd0, 32'hFFFFFFFF, 32'd1,        32'h10, 32'd0,        32'd0,        1'b0};
        vecs[10] = '{A_ADD,  1'b1, 2'b00, OP_JALR, 1'b1, 3'b000, 1'b0, 3'd0, 32'h1003,     32'd0,        32'd4,  32'h1006,     32'h1006,     1'b1};
        vecs[11] = '{A_ADD,  1'b1, 2'b00, OP_JAL,  1'b1, 3'b000, 1'b0, 3'd0, 32'd0,        32'd0,        32'd8,  32'd8,        32'd8,        1'b1};
        vecs[12] = '{A_SRA,  1'b0, 2'b00, OP_R,    1'b0, 3'b000, 1'b0, 3'd0, 32'h80000000, 32'd4,        32'd0,  32'hF8000000, 32'hF8000000, 1'b0};
        vecs[13] = '{A_SRL,  1'b0, 2'b00, OP_R,    1'b0, 3'b000, 1'b0, 3'd0, 32'h80000000, 32'd4,        32'd0,  32'h08000000, 32'h08000000, 1'b0};
        vecs[14] = '{A_XOR,  1'b0, 2'b00, OP_R,    1'b0, 3'b000, 1'b0, 3'd0, 32'hF0F0,     32'h0FF0,     32'd0,  32'hFF00,     32'hFF00,     1'b0};
        vecs[15] = '{A_ADD,  1'b0, 2'b00, OP_R,    1'b0, 3'b000, 1'b1, 3'd1, 32'hFFFFFFFE, 32'd3,        32'd0,  32'hFFFFFFFF, 32'd1,        1'b0};
        vecs[16] = '{A_XOR,  1'b0, 2'b00, OP_R,    1'b0, 3'b000, 1'b1, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,  32'hFFFFFFFE, 32'd0,        1'b0};
        vecs[17] = '{A_ADD,  1'b0, 2'b00, OP_R,    1'b0, 3'b000, 1'b1, 3'd0, 32'd7,        32'd6,        32'd0,  32'd42,       32'd13,       1'b0};
        vecs[18] = '{A_ADD,  1'b0, 2'b00, OP_R,    1'b0, 3'b000, 1'b1, 3'd2, 32'hFFFFFFFF, 32'd2,        32'd0,  32'hFFFFFFFF, 32'd1,        1'b0};
        vecs[19] = '{A_ADD,  1'b0, 2'b00, OP_R,    1'b0, 3'b000, 1'b1, 3'd5, 32'd9,        32'd0,        32'd0,  32'hFFFFFFFF, 32'd9,        1'b0};
        vecs[20] = '{A_ADD,  1'b0, 2'b00, OP_R,    1'b0, 3'b000, 1'b1, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'd0,  32'h80000000, 32'h7FFFFFFF, 1'b0};
        vecs[21] = '{A_ADD,  1'b0, 2'b00, OP_R,    1'b0, 3'b000, 1'b1, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,  32'd0,        32'h7FFFFFFF, 1'b0};
        vecs[22] = '{A_ADD,  1'b0, 2'b00, OP_R,    1'b0, 3'b000, 1'b1, 3'd7, 32'd9,        32'd0,        32'd0,  32'd9,        32'd9,        1'b0};
        vecs[23] = '{A_SUB,  1'b0, 2'b00, OP_R,    1'b0, 3'b000, 1'b1, 3'd4, 32'hFFFFFFF9, 32'd0,        32'd0,  32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};

        rst = 1'b0;
        set_instr(A_ADD, 1'b0, 2'b00, OP_R, 1'b0, 3'b000, 1'b0, 3'd0, 32'd1, 32'd2, 32'd0);
        pc = 32'h1000; pc_plus4 = 32'h1004; wb_data = 32'h55; rd = 5'd3;
        result_sel = 2'b01; mem_type = 2'b10; mem_unsigned = 1'b1;

        // Reset state
        @(posedge clk); #1;
        chk("rst_alu_result", alu_result_o, 32'd0);
        chk("rst_reg_write", {31'd0, reg_write_o}, 32'd0);
        chk("rst_mem_type", {30'd0, mem_type_o}, 32'd0);
        chk("rst_pc_plus4", pc_plus4_o, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Single-cycle vector table
        for (int i = 0; i < 24; i++) begin
            set_instr(vecs[i].ctrl, vecs[i].src, vecs[i].fa, vecs[i].opc, vecs[i].br, vecs[i].bt,
                      vecs[i].mden, vecs[i].mdop, vecs[i].a, vecs[i].b, vecs[i].im);
            pc = 32'h1000 + 32'(i * 16);
            rd = 5'(i);
            #3;
            chk($sformatf("vec%0d_stall", i), {31'd0, stall_o}, 32'd0);
            chk($sformatf("vec%0d_pc_src", i), {31'd0, pc_src}, {31'd0, vecs[i].exp_pcs});
            if (vecs[i].br) chk($sformatf("vec%0d_pc_branch", i), pc_branch, pc + vecs[i].im);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_result", i), alu_result_o, MD ? vecs[i].exp_md : vecs[i].exp_alu);
            chk($sformatf("vec%0d_wdata", i), wdata_o, vecs[i].b);
            chk($sformatf("vec%0d_rd", i), {27'd0, rd_o}, i);
            chk($sformatf("vec%0d_reg_write", i), {31'd0, reg_write_o}, 32'd1);
        end
        chk("mem_type_pass", {30'd0, mem_type_o}, 32'd2);

        // DIV -7/2 and REM -7/2
        run_div(3'd4, 32'hFFFFFFF9, 32'd2, st, bb, dn);
        chk("div_done", {31'd0, dn}, 32'd1);
        chk("div_stall_cycles", st, MD ? 32'd33 : 32'd0);
        chk("div_bubbles", bb, MD ? 32'd33 : 32'd0);
        chk("div_result", alu_result_o, MD ? 32'hFFFFFFFD : 32'hFFFFFFFB);
        chk("div_reg_write", {31'd0, reg_write_o}, 32'd1);
        run_div(3'd6, 32'hFFFFFFF9, 32'd2, st, bb, dn);
        chk("rem_done", {31'd0, dn}, 32'd1);
        chk("rem_stall_cycles", st, MD ? 32'd33 : 32'd0);
        chk("rem_result", alu_result_o, MD ? 32'hFFFFFFFF : 32'hFFFFFFFB);
        run_div(3'd5, 32'd100, 32'd7, st, bb, dn);
        chk("divu_result", alu_result_o, MD ? 32'd14 : 32'd107);
        run_div(3'd6, 32'd100, 32'hFFFFFFF9, st, bb, dn);
        chk("rem_neg_divisor", alu_result_o, MD ? 32'd2 : 32'd93);

        // Flush at BUSY cycle 10
        set_instr(A_ADD, 1'b0, 2'b00, OP_R, 1'b0, 3'b000, 1'b1, 3'd5, 32'd100, 32'd3, 32'd0);
        repeat (11) begin
            @(posedge clk); #1;
        end
        #2;
        chk("busy_stall", {31'd0, stall_o}, {31'd0, MD});
        flush = 1'b1;
        #1;
        chk("flush_stall_drop", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        chk("flush_bubble", {31'd0, reg_write_o}, 32'd0);
        set_instr(A_ADD, 1'b0, 2'b00, OP_R, 1'b0, 3'b000, 1'b0, 3'd0, 32'd1, 32'd2, 32'd0);
        #3;
        chk("after_flush_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        chk("after_flush_result", alu_result_o, 32'd3);
        chk("after_flush_reg_write", {31'd0, reg_write_o}, 32'd1);

        // Reset mid-divide
        set_instr(A_ADD, 1'b0, 2'b00, OP_R, 1'b0, 3'b000, 1'b1, 3'd4, 32'd100, 32'd3, 32'd0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #2;
        chk("midrst_stall", {31'd0, stall_o}, 32'd0);
        chk("midrst_alu_result", alu_result_o, 32'd0);
        chk("midrst_op", {25'd0, op_o}, 32'd0);
        chk("midrst_rd", {27'd0, rd_o}, 32'd0);
        chk("midrst_wdata", wdata_o, 32'd0);
        chk("midrst_mem_type", {30'd0, mem_type_o}, 32'd0);
        chk("midrst_mem_unsigned", {31'd0, mem_unsigned_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        set_instr(A_SUB, 1'b0, 2'b00, OP_R, 1'b0, 3'b000, 1'b0, 3'd0, 32'd10, 32'd4, 32'd0);
        #3;
        chk("post_rst_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        chk("post_rst_result", alu_result_o, 32'd6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/exec_stage_md.md
# exec_stage_md

Parametrised execute stage (ID/EX → EX/MEM) for the pipelined RISC-V core with an integrated RV32M multiply/divide unit. Performs operand forwarding, ALU and branch/jump resolution as before, adds single-cycle MUL family and an iterative DIV/REM engine that stalls upstream, then registers results into the EX/MEM pipeline register. Sits between the ID/EX register and the memory stage; stall output goes to the hazard unit.

## Interface
- XLEN, 32, datapath width (≥8, power of two)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  kill the instruction currently in EX
- op  in  7  opcode; op_o  out  7  registered
- alu_ctrl  in  4  ALU operation; alu_src  in  1  0=rs2, 1=imm
- md_en  in  1  M-extension instruction; md_op  in  3  funct3 (MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU = 0..7)
- fwd_a, fwd_b  in  2  00=rdata, 01=wb_data, 10=alu_result_o
- rdata1, rdata2, imm, pc, pc_plus4, wb_data  in  XLEN
- rd  in  5; branch  in  1; branch_type  in  3; reg_write, mem_write  in  1; result_sel  in  2; mem_type  in  2; mem_unsigned  in  1
- pc_branch  out  XLEN  pc+imm (combinational); pc_src  out  1  redirect taken (combinational)
- stall_o  out  1  EX busy, upstream must hold (combinational)
- reg_write_o, mem_write_o  out  1; result_sel_o  out  2; rd_o  out  5; pc_plus4_o, wdata_o, alu_result_o  out  XLEN; mem_type_o  out  2; mem_unsigned_o  out  1

## Operation
- Operand A = fwd_a mux; B_raw = fwd_b mux; B = alu_src ? imm : B_raw; fwd code 11 selects rdata.
- JALR (op 1100111): result LSB forced 0.
- pc_src = !flush & branch & (BEQ&zero | BNE&!zero | BLT/BLTU&res[0] | BGE/BGEU&!res[0] | op==1101111 | op==1100111); BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
- MUL family: 2·XLEN product, signedness per md_op; MUL low half, others high half; same timing as ALU op.
- DIV family FSM IDLE → BUSY → DONE → IDLE:
  - IDLE, md_en & md_op≥4 & !flush & no special case: stall_o=1; at edge capture |A|, |B_raw|, sign flags, md_op into internal regs; counter=0; → BUSY.
  - BUSY: restoring radix-2, one quotient bit per cycle, XLEN cycles; stall_o=1; → DONE after bit XLEN-1.
  - DONE: stall_o=0; sign-corrected quotient/remainder drives result; EX/MEM loads; → IDLE.
  - Special cases complete in one cycle, no stall: divisor 0 → quotient all-ones, remainder = dividend; signed −2^(XLEN−1)/−1 → quotient = dividend, remainder 0.
  - Remainder sign = dividend sign; quotient negated when signs differ (signed ops only).
- EX/MEM register: loads all fields each cycle; wdata_o = B_raw. While stall_o=1 or flush=1 loads a bubble: reg_write_o=0, mem_write_o=0, other fields don't-care but deterministic (loaded as normal).
- flush in BUSY or DONE: abort, → IDLE at next edge; stall_o drops in the flush cycle; bubble inserted.

## Timing
- Reset: every registered output 0 (incl. mem_type_o), FSM IDLE, counter 0.
- ALU/MUL/special-case DIV: 1 cycle in EX; result visible on alu_result_o after the next edge.
- Normal DIV: XLEN+2 cycles in EX (issue, XLEN BUSY, DONE); stall_o high XLEN+1 cycles; XLEN+1 bubbles into MEM.
- Operands are captured at issue; fwd changes during stall have no effect.
- ID/EX inputs must stay stable while stall_o=1; in DONE they supply rd/control fields.
- Reset mid-division: immediate IDLE, stall_o=0.

## Configuration
- EXEC_MD_EXT_EN defined: multiplier, divider, FSM and stall logic present as above.
- Not defined: md_en and md_op ignored, instruction executes as ALU op per alu_ctrl, stall_o tied 0, no MDU logic.

## Test plan
- ADD 5+7 with fwd_a=10 (alu_result_o=100) → alu_result_o=107 next cycle, pc_src=0.
- BNE rs1=3, rs2=3 (alu_ctrl SUB) → pc_src=0; rs2=4 → pc_src=1, pc_branch=pc+imm.
- MULH −2 × 3 (XLEN=32) → alu_result_o=0xFFFFFFFF after 1 cycle, stall_o never high.
- DIV −7 / 2 → stall_o high 33 cycles, 33 bubbles, then alu_result_o=0xFFFFFFFD; REM → 0xFFFFFFFF.
- DIVU 9 / 0 → 0xFFFFFFFF in 1 cycle; DIV 0x80000000 / −1 → 0x80000000; REM → 0.
- DIV issued, flush at BUSY cycle 10 → stall_o low same cycle, FSM IDLE, reg_write_o=0; rst low mid-divide → all outputs 0.
